// File: rtl/instr_encoder.sv
// Encodes structured instruction requests into RV32I/Zicsr words, expanding LI
// into LUI/ADDI, behind valid/ready handshakes with one registered output stage.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_class,
  input  logic [2:0]  req_f3,
  input  logic        req_alt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_word,
  output logic        ins_last,
  output logic        err
);

  typedef enum logic [1:0] {EMPTY, ONE, FIRST} state_t;

  state_t      r_state;
  logic [31:0] r_word;
  logic [31:0] r_pend;
  logic        r_err;

  logic [31:0] w_word0;
  logic [31:0] w_word1;
  logic        w_two;
  logic        w_illegal;
  logic [6:0]  w_f7;
  logic [19:0] w_hi;
  logic        w_small;
  logic        w_accept;

  assign w_f7    = req_alt ? 7'b0100000 : 7'b0000000;
  // (imm + 0x800)[31:12] computed as the upper field plus the rounding bit
  assign w_hi    = req_imm[31:12] + {19'd0, req_imm[11]};
  assign w_small = (req_imm[31:11] == '0) || (req_imm[31:11] == '1);

  always_comb begin
    w_word0   = '0;
    w_word1   = '0;
    w_two     = 1'b0;
    w_illegal = 1'b0;
    case (req_class)
      4'd0: begin
        w_illegal = req_alt && (req_f3 != 3'b000) && (req_f3 != 3'b101);
        w_word0   = {w_f7, req_rs2, req_rs1, req_f3, req_rd, 7'b0110011};
      end
      4'd1: begin
        w_illegal = req_alt && (req_f3 != 3'b101);
        if (req_f3 == 3'b001 || req_f3 == 3'b101)
          w_word0 = {w_f7, req_imm[4:0], req_rs1, req_f3, req_rd, 7'b0010011};
        else
          w_word0 = {req_imm[11:0], req_rs1, req_f3, req_rd, 7'b0010011};
      end
      4'd2: begin
        w_illegal = (req_f3 == 3'b011) || (req_f3 == 3'b110) || (req_f3 == 3'b111);
        w_word0   = {req_imm[11:0], req_rs1, req_f3, req_rd, 7'b0000011};
      end
      4'd3: begin
        w_illegal = (req_f3 > 3'b010);
        w_word0   = {req_imm[11:5], req_rs2, req_rs1, req_f3, req_imm[4:0], 7'b0100011};
      end
      4'd4: begin
        w_illegal = (req_f3 == 3'b010) || (req_f3 == 3'b011);
        w_word0   = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_f3,
                     req_imm[4:1], req_imm[11], 7'b1100011};
      end
      4'd5: w_word0 = {req_imm[31:12], req_rd, 7'b0110111};
      4'd6: w_word0 = {req_imm[31:12], req_rd, 7'b0010111};
      4'd7: w_word0 = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                       req_rd, 7'b1101111};
      4'd8: w_word0 = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b1100111};
      4'd9: w_word0 = {req_imm[11:0], req_rs1, 3'b001, req_rd, 7'b1110011};
      4'd10: w_word0 = 32'h30200073;
      4'd11: begin
        if (w_small) begin
          w_word0 = {req_imm[11:0], 5'd0, 3'b000, req_rd, 7'b0010011};
        end else begin
          w_word0 = {w_hi, req_rd, 7'b0110111};
          w_word1 = {req_imm[11:0], req_rd, 3'b000, req_rd, 7'b0010011};
          w_two   = (req_imm[11:0] != '0);
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign req_ready = !rst && (r_state == EMPTY || (r_state == ONE && ins_ready));
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_word  <= '0;
      r_pend  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_accept && !w_illegal) begin
        r_word  <= w_word0;
        r_pend  <= w_word1;
        r_state <= w_two ? FIRST : ONE;
      end else if (r_state == FIRST && ins_ready) begin
        r_word  <= r_pend;
        r_state <= ONE;
      end else if (r_state == ONE && ins_ready) begin
        r_state <= EMPTY;
      end
    end
  end

  assign ins_valid = (r_state != EMPTY);
  assign ins_last  = (r_state == ONE);
  assign ins_word  = r_word;
  assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed encodings.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_class;
  logic [2:0]  req_f3;
  logic        req_alt;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_word;
  logic        ins_last;
  logic        err;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  instr_encoder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_f3(req_f3), .req_alt(req_alt),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_word(ins_word), .ins_last(ins_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request and hold it until accepted; returns at the negedge after acceptance.
  task automatic do_req(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
    bit done = 0;
    req_class = cls; req_f3 = f3; req_alt = alt;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (req_ready) done = 1;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!done) check("req_timeout", 32'd0, 32'd1);
  endtask

  // Expect a word on the output at this negedge, then let it drain (ins_ready high).
  task automatic expect_word(input string tag, input logic [31:0] exp, input logic last);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (ins_valid) seen = 1;
      else @(negedge clk);
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    check(tag, ins_word, exp);
    check({tag, "_last"}, {31'd0, ins_last}, {31'd0, last});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; ins_ready = 1'b1;
    req_class = '0; req_f3 = '0; req_alt = 1'b0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_word", ins_word, 32'd0);
    check("rst_last", {31'd0, ins_last}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, req_ready}, 32'd1);

    do_req(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("add", 32'h002081B3, 1'b1);
    do_req(4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("sub", 32'h402081B3, 1'b1);
    do_req(4'd1, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3);
    expect_word("srai", 32'h40315093, 1'b1);

    do_req(4'd11, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    check("li_first_ready", {31'd0, req_ready}, 32'd0);
    expect_word("li_lui", 32'h123462B7, 1'b0);
    expect_word("li_addi", 32'hFFF28293, 1'b1);

    do_req(4'd11, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFB);
    expect_word("li_neg5", 32'hFFB00293, 1'b1);
    do_req(4'd11, 3'b000, 1'b0, 5'd6, 5'd0, 5'd0, 32'h00010000);
    expect_word("li_lui_only", 32'h00010337, 1'b1);
    do_req(4'd11, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'd2047);
    expect_word("li_2047", 32'h7FF00293, 1'b1);
    do_req(4'd11, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'd2048);
    expect_word("li_2048_lui", 32'h000012B7, 1'b0);
    expect_word("li_2048_addi", 32'h80028293, 1'b1);
    do_req(4'd11, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFF800);
    expect_word("li_m2048", 32'h80000293, 1'b1);
    do_req(4'd11, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFF7FF);
    expect_word("li_m2049_lui", 32'hFFFFF2B7, 1'b0);
    expect_word("li_m2049_addi", 32'h7FF28293, 1'b1);

    do_req(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_word("beq", 32'h00208463, 1'b1);
    do_req(4'd10, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    expect_word("mret", 32'h30200073, 1'b1);
    do_req(4'd3, 3'b010, 1'b0, 5'd0, 5'd2, 5'd3, 32'd4);
    expect_word("sw", 32'h00312223, 1'b1);
    do_req(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    expect_word("jal", 32'h008000EF, 1'b1);
    do_req(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hABCDE000);
    expect_word("lui", 32'hABCDE0B7, 1'b1);
    do_req(4'd9, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'h00000300);
    expect_word("csrrw", 32'h300110F3, 1'b1);

    // illegal requests: consumed, no word, single-cycle err
    do_req(4'd3, 3'b011, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0);
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_valid", {31'd0, ins_valid}, 32'd0);
    @(negedge clk);
    check("ill_err_pulse", {31'd0, err}, 32'd0);
    check("ill_valid2", {31'd0, ins_valid}, 32'd0);
    do_req(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("add_after_ill", 32'h002081B3, 1'b1);
    do_req(4'd12, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    check("ill_cls_err", {31'd0, err}, 32'd1);
    check("ill_cls_valid", {31'd0, ins_valid}, 32'd0);
    @(negedge clk);

    // backpressure on the LUI word
    ins_ready = 1'b0;
    do_req(4'd11, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    for (int i = 0; i < 3; i++) begin
      check("bp_word", ins_word, 32'h123462B7);
      check("bp_valid", {31'd0, ins_valid}, 32'd1);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    ins_ready = 1'b1;
    expect_word("bp_lui", 32'h123462B7, 1'b0);
    expect_word("bp_addi", 32'hFFF28293, 1'b1);

    // reset while the ADDI is pending
    ins_ready = 1'b0;
    do_req(4'd11, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    check("rf_first_valid", {31'd0, ins_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rf_valid", {31'd0, ins_valid}, 32'd0);
    check("rf_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    ins_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rf_no_addi", {31'd0, ins_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Stream encoder that converts structured instruction requests (class, func3, alt, register indices, immediate) into 32-bit RV32I/Zicsr instruction words. It is the inverse of the core's control decoder. It sits between the GEMM command sequencer and the instruction memory write port or the core fetch inject path. It also expands the LI pseudo-instruction into an LUI/ADDI pair. Valid/ready handshakes are used on both sides, with a single registered output stage.

## Interface
- No parameters.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_class  in  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 CSRRW, 10 MRET, 11 LI; 12–15 illegal.
- req_f3  in  3  func3.
- req_alt  in  1  selects func7 = 0100000 (SUB/SRA/SRAI).
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_imm  in  32  immediate, full byte value.
- ins_valid  out  1  ins_word valid.
- ins_ready  in  1  downstream accepts.
- ins_word  out  32  encoded instruction.
- ins_last  out  1  word is the final word of its request.
- err  out  1  one-cycle pulse when an illegal request is accepted.

## Operation
- Opcodes:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 (f3 forced 000).
  - CSRRW 1110011 with f3=001 and csr=req_imm[11:0].
  - MRET is the constant 0x30200073.
- Immediates:
  - I: req_imm[11:0].
  - S: req_imm[11:5] to [31:25], req_imm[4:0] to [11:7].
  - B: req_imm[12|10:5|4:1|11]. req_imm[0] is ignored.
  - U: req_imm[31:12].
  - J: req_imm[20|10:1|11|19:12].
- I-ALU with f3 001/101: shamt=req_imm[4:0], func7=req_alt?0100000:0000000.
- Illegal requests:
  - R with req_alt and f3∉{000,101}.
  - I-ALU with req_alt and f3≠101.
  - LOAD with f3∈{011,110,111}.
  - STORE with f3>010.
  - BRANCH with f3∈{010,011}.
  - class ≥12.
  - Behavior: the request is consumed, no word is emitted, and err pulses.
- LI rd, imm:
  - If imm is in [-2048, 2047]: single ADDI rd,x0,imm[11:0].
  - Otherwise: hi=(imm+0x800)[31:12]. Emit LUI rd,hi, then ADDI rd,rd,imm[11:0] only if imm[11:0]≠0.
- FSM states:
  - EMPTY: no word held.
  - ONE: holding a last word.
  - FIRST: holding LUI with an ADDI pending. The pending ADDI is latched at acceptance.
- Transitions:
  - EMPTY/ONE with accept of a single-word request → ONE.
  - Accept of a two-word LI → FIRST.
  - FIRST with ins_ready → ONE, loading the ADDI.
  - ONE with ins_ready and no accept → EMPTY.
  - Illegal accept → EMPTY, or ONE draining.
- req_ready = !rst && (state==EMPTY || (state==ONE && ins_ready)). This is a combinational path from ins_ready.
- ins_valid = state≠EMPTY. ins_last = (state==ONE).

## Timing
- Reset values: ins_valid=0, ins_word=0, ins_last=0, err=0, state EMPTY. req_ready=0 while rst=1.
- Latency: the word is valid in the cycle after acceptance.
- Throughput: 1 word/cycle with ins_ready held high. A two-word LI blocks req_ready for one extra cycle.
- ins_word, ins_last and ins_valid stay stable while ins_valid && !ins_ready.
- err is asserted in the cycle after the illegal acceptance, for exactly one cycle.
- Simultaneous drain and accept in ONE: the new word replaces the old one with no bubble.
- Reset mid-expansion: a pending ADDI is discarded, and the output is EMPTY in the next cycle.

## Test plan
- R ADD rd=3, rs1=1, rs2=2 → ins_word 0x002081B3, ins_last=1, one cycle after accept.
- LI rd=5, imm=0x12345FFF → 0x123462B7 (ins_last=0), then 0xFFF28293 (ins_last=1). req_ready is low during the first word.
- LI rd=5, imm=-5 → single 0xFFB00293. LI rd=6, imm=0x00010000 → single LUI 0x00010337.
- BRANCH f3=000, rs1=1, rs2=2, imm=8 → 0x00208463. MRET → 0x30200073.
- STORE f3=011 → err pulse of one cycle, ins_valid stays 0. The next ADD request is then encoded normally.
- Backpressure: hold ins_ready=0 for 3 cycles during the LI LUI word → word held stable, req_ready=0. Assert rst during FIRST → next cycle ins_valid=0, and the ADDI is never emitted.
